tinyalu_core: RTL and testbench



---
 rtl/tinyalu_core_if.sv | 36 +++
 rtl/tinyalu_core.sv | 176 +++++++++++++++++
 tb/tb_tinyalu_core.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/tinyalu_core_if.sv
// TinyALU start/done operation bus between an initiator and the ALU responder.
// Latency: none (wires only); the responder defines operation timing.
// Backpressure: start is level-held by the initiator until done; no other flow control.
//
// Signals:
//   A, B    8-bit unsigned operands         (initiator -> responder)
//   op      3-bit opcode                    (initiator -> responder)
//   start   request, held until done seen   (initiator -> responder)
//   done    one-cycle completion pulse      (responder -> initiator)
//   result  16-bit registered result        (responder -> initiator)
interface tinyalu_core_if;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;

    modport master (
        output A,
        output B,
        output op,
        output start,
        input  done,
        input  result
    );

    modport slave (
        input  A,
        input  B,
        input  op,
        input  start,
        output done,
        output result
    );
endinterface

// File: rtl/tinyalu_core.sv
// TinyALU responder: latches operands/opcode on start, executes add/and/xor/mul, returns registered result.
// Latency: add/and/xor/illegal done one edge after acceptance; mul done three edges after acceptance.
// Backpressure: none; start is held by the initiator and re-armed only after it drops following done.
//
// Ports:
//   clk    single rising-edge clock
//   reset  synchronous, active-high reset (discards any in-flight operation)
//   bus    tinyalu_core_if.slave: A, B, op, start in; done, result out
//
// Build option: define TINYALU_MUL_EN to build the MUL state, its cycle counter
// and the 8x8 multiplier. When undefined, opcode 4 takes the illegal-opcode path
// (result 0, done one edge after acceptance).
module tinyalu_core (
    input  logic          clk,
    input  logic          reset,
    tinyalu_core_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        MUL   = 2'd2,
        REARM = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_RST = 3'd7;
`ifdef TINYALU_MUL_EN
    localparam logic [2:0] OP_MUL = 3'd4;
`endif

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  a_q;
    logic [7:0]  a_d;
    logic [7:0]  b_q;
    logic [7:0]  b_d;
    logic [2:0]  op_q;
    logic [2:0]  op_d;
    logic [15:0] result_q;
    logic [15:0] result_d;
    logic        done_q;
    logic        done_d;

    // 9-bit sum so the carry lands in bit 8 of the result.
    logic [8:0]  sum;
    assign sum = {1'b0, a_q} + {1'b0, b_q};

`ifdef TINYALU_MUL_EN
    // Counter is loaded with 2 on acceptance; the product is written on the
    // cycle the counter is found at 0, giving completion three edges later.
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [15:0] prod;
    assign prod = {8'b0, a_q} * {8'b0, b_q};
`endif

    // Next-state and datapath decode. Only the latched operands feed the
    // arithmetic, so bus changes after acceptance have no effect.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        done_d   = 1'b0;
`ifdef TINYALU_MUL_EN
        cnt_d    = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d  = bus.A;
                    b_d  = bus.B;
                    op_d = bus.op;
                    case (bus.op)
                        OP_NOP: begin
                            // Accepted but inert; a held start re-samples next cycle.
                            state_d = IDLE;
                        end
                        OP_RST: begin
                            // Soft reset clears the result without a done pulse.
                            result_d = 16'h0000;
                            state_d  = IDLE;
                        end
`ifdef TINYALU_MUL_EN
                        OP_MUL: begin
                            cnt_d   = 2'd2;
                            state_d = MUL;
                        end
`endif
                        default: begin
                            // add/and/xor and every illegal opcode complete via EXEC,
                            // so the initiator always gets a done.
                            state_d = EXEC;
                        end
                    endcase
                end
            end

            EXEC: begin
                case (op_q)
                    OP_ADD:  result_d = {7'b0, sum};
                    OP_AND:  result_d = {8'b0, a_q & b_q};
                    OP_XOR:  result_d = {8'b0, a_q ^ b_q};
                    default: result_d = 16'h0000;
                endcase
                done_d  = 1'b1;
                state_d = REARM;
            end

`ifdef TINYALU_MUL_EN
            MUL: begin
                if (cnt_q == 2'd0) begin
                    result_d = prod;
                    done_d   = 1'b1;
                    state_d  = REARM;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
`endif

            REARM: begin
                // A start still held from the finished request must not be
                // taken as a new one; wait for it to drop.
                if (!bus.start) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            op_q     <= 3'd0;
            result_q <= 16'h0000;
            done_q   <= 1'b0;
`ifdef TINYALU_MUL_EN
            cnt_q    <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            done_q   <= done_d;
`ifdef TINYALU_MUL_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.done   = done_q;
    assign bus.result = result_q;

    // done is a single-cycle pulse: completion always moves on to REARM.
    done_single_cycle: assert property (@(posedge clk) disable iff (reset) done_q |=> !done_q);

    // Completion only ever comes out of EXEC or MUL.
    done_from_busy: assert property (@(posedge clk) disable iff (reset)
        (state_q == IDLE || state_q == REARM) |=> !done_q);

endmodule

// File: tb/tb_tinyalu_core.sv
// Self-checking bench for tinyalu_core: directed protocol cases plus randomized operations.
// Driver pushes expected result and completion cycle to a scoreboard; a monitor pops on done.
// Initiator drops start on the falling edge after seeing done (optionally holding it longer).
module tb_tinyalu_core;

    logic clk = 1'b0;
    logic reset;

    tinyalu_core_if bus ();

    tinyalu_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef TINYALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    // Edge counter: after posedge k, cyc == k when sampled on the negedge.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        int unsigned due;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] model_res;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference behaviour computed from the opcode table with plain arithmetic.
    function automatic logic [15:0] ref_result(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned r;
        case (o)
            3'd1:    r = x + y;
            3'd2:    r = x & y;
            3'd3:    r = x ^ y;
            3'd4:    r = MUL_EN ? x * y : 0;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    function automatic int unsigned ref_latency(input logic [2:0] o);
        return (o == 3'd4 && MUL_EN) ? 3 : 1;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation,
    // in both value and completion edge.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("stray_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, {16'h0, bus.result}, {16'h0, e.res});
                check({e.name, "_latency"}, cyc, e.due);
            end
        end
    end

    // Initiator: raise start on a negedge so the following posedge accepts.
    // hold = extra cycles start stays high after done (or after a no-done op).
    task automatic send_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                           input int hold, input bit drop_early, input string name);
        int unsigned n;
        logic [15:0] e;
        bit          seen;
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.op    = o;
        bus.start = 1'b1;
        n = cyc + 1;
        if (o == 3'd0 || o == 3'd7) begin
            @(negedge clk);
            if (o == 3'd7) begin
                model_res = 16'h0000;
            end
            check({name, "_result"}, {16'h0, bus.result}, {16'h0, model_res});
            if (o == 3'd0) begin
                repeat (hold) @(negedge clk);
            end
            bus.start = 1'b0;
        end else begin
            e = ref_result(o, a, b);
            sb.push_back('{e, n + ref_latency(o), name});
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (i == 0) begin
                    // Operands and opcode after acceptance must be ignored.
                    bus.A  = 8'($urandom);
                    bus.B  = 8'($urandom);
                    bus.op = 3'($urandom_range(0, 7));
                    if (drop_early) bus.start = 1'b0;
                end
                if (bus.done === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            check({name, "_done_seen"}, {31'h0, seen}, 32'd1);
            model_res = e;
            repeat (hold) @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a live add request: nothing may be accepted.
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'd1;
        bus.A     = 8'h05;
        bus.B     = 8'h06;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_done", {31'h0, bus.done}, 32'd0);
            check("reset_result", {16'h0, bus.result}, 32'd0);
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("post_reset_done", {31'h0, bus.done}, 32'd0);
        model_res = 16'h0000;

        // Single-cycle ops and multiply.
        send_op(3'd1, 8'hFF, 8'h01, 0, 1'b0, "add_ff_01");
        send_op(3'd2, 8'hF0, 8'h3C, 0, 1'b0, "and_f0_3c");
        send_op(3'd3, 8'hF0, 8'h3C, 0, 1'b0, "xor_f0_3c");
        send_op(3'd4, 8'hFF, 8'hFF, 0, 1'b0, "mul_ff_ff");

        // Re-arm: start held 4 cycles past done gives one done; then 1 low cycle and xor.
        send_op(3'd1, 8'h12, 8'h34, 4, 1'b0, "add_held");
        send_op(3'd3, 8'hA5, 8'h0F, 0, 1'b0, "xor_after_rearm");

        // Special opcodes.
        send_op(3'd0, 8'h11, 8'h22, 3, 1'b0, "noop_held");
        send_op(3'd1, 8'hFF, 8'h01, 0, 1'b0, "add_before_rst");
        send_op(3'd7, 8'h00, 8'h00, 0, 1'b0, "rst_op");
        send_op(3'd5, 8'h33, 8'h44, 0, 1'b0, "illegal_5");
        send_op(3'd6, 8'h55, 8'h66, 0, 1'b0, "illegal_6");
        send_op(3'd4, 8'h07, 8'h09, 0, 1'b1, "mul_start_dropped");

        // Abort: reset one cycle after a mul is accepted.
        @(negedge clk);
        bus.A     = 8'd2;
        bus.B     = 8'd3;
        bus.op    = 3'd4;
        bus.start = 1'b1;
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("abort_done", {31'h0, bus.done}, 32'd0);
        check("abort_result", {16'h0, bus.result}, 32'd0);
        reset = 1'b0;
        model_res = 16'h0000;
        repeat (4) @(negedge clk);
        send_op(3'd4, 8'd2, 8'd3, 0, 1'b0, "mul_after_abort");

        // Randomized operations.
        for (int k = 0; k < 60; k++) begin
            logic [2:0] o;
            o = 3'($urandom_range(0, 7));
            send_op(o, 8'($urandom), 8'($urandom), (o == 3'd7) ? 0 : int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), $sformatf("rand%0d_op%0d", k, o));
        end

        repeat (6) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
